// File: rtl/vport_pkg.sv
// vport_pkg: shared definitions for the pixel-stream-to-video-port stage.
//   - RGB555 field offsets within a stream word
//   - 5-to-8 bit colour expansion by bit replication
//   - FSM state encoding (SYNC waits for a frame start, RUN displays pixels)
package vport_pkg;

  localparam int C5_W  = 5;
  localparam int R_LSB = 10;
  localparam int G_LSB = 5;
  localparam int B_LSB = 0;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } vport_state_e;

  // Replicating the top bits fills the low end so that full scale maps to
  // full scale (5'h1F -> 8'hFF) and mid scale stays near mid (5'h10 -> 8'h84).
  function automatic logic [7:0] expand5(input logic [C5_W-1:0] c5);
    return {c5, c5[4:2]};
  endfunction

endpackage

// File: rtl/vport_fifo.sv
// vport_fifo: synchronous show-ahead register FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write a word when push=1 and the FIFO is not full
//   pop        : drop the head word when pop=1 and the FIFO is not empty
//   head       : current head word, valid whenever empty=0 (no fall-through:
//                a word written this cycle is visible from the next cycle)
//   empty      : no words stored
//   count      : number of stored words, 0..DEPTH
module vport_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset: contents are meaningless until count says so.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fb_stream_to_vport.sv
// fb_stream_to_vport: converts the RGB555 pixel stream from the video arbiter
// into RGB888 + HS/VS/DE for the DVI serializer.
//   iCLK, iRESETn           : pixel clock, asynchronous active-low reset
//   iST_DATA/iST_DV/iST_START: input stream word, valid, first-pixel-of-frame
//   oST_READY               : stage accepts a word this cycle
//   oRED/oGRN/oBLU          : 8-bit colour, registered
//   oHS/oVS/oDE             : sync and data-enable, registered
//   oUNDERRUN               : sticky error (underrun / misaligned frame)
//   iCLR_UNDERRUN           : synchronous clear of oUNDERRUN (a new error wins)
//   oDBG_STATE              : current FSM state
//
// Handshake: a word transfers on a clock edge where iST_DV=1 and oST_READY=1;
// iST_DV=0 words are ignored, and oST_READY is a register that only promises
// room for one more word, so the FIFO can never overflow.
//
// Raster timing is free-running; the FSM only decides what colour to show.
// In SYNC it discards non-start words and waits for a start word at (0,0);
// in RUN any disagreement between the stream and the raster drops back to
// SYNC and flags oUNDERRUN, so the picture realigns at the next frame.
module fb_stream_to_vport
  import vport_pkg::*;
#(
  parameter int          H_ACTIVE     = 640,
  parameter int          H_FP         = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BP         = 48,
  parameter int          V_ACTIVE     = 480,
  parameter int          V_FP         = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BP         = 33,
  parameter bit          HS_POL       = 1'b0,
  parameter bit          VS_POL       = 1'b0,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [23:0] UNDERRUN_RGB = 24'h0000FF
) (
  input  logic         iCLK,
  input  logic         iRESETn,
  input  logic [14:0]  iST_DATA,
  input  logic         iST_DV,
  input  logic         iST_START,
  output logic         oST_READY,
  output logic [7:0]   oRED,
  output logic [7:0]   oGRN,
  output logic [7:0]   oBLU,
  output logic         oHS,
  output logic         oVS,
  output logic         oDE,
  output logic         oUNDERRUN,
  input  logic         iCLR_UNDERRUN,
  output vport_state_e oDBG_STATE
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_DE_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_DE_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          de_raw;
  logic          hs_raw;
  logic          vs_raw;
  logic          at_origin;

  vport_state_e  state;
  vport_state_e  state_next;

  logic          push;
  logic          pop;
  logic [15:0]   head;
  logic          head_start;
  logic [14:0]   head_pix;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_next;
  logic [23:0]   head_rgb;
  logic [23:0]   pix_rgb;
  logic          err;

  // ---------------------------------------------------------------- timing
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  assign de_raw    = (hcnt < H_DE_END) && (vcnt < V_DE_END);
  assign hs_raw    = (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign vs_raw    = (vcnt >= VS_BEG) && (vcnt < VS_END);
  assign at_origin = (hcnt == '0) && (vcnt == '0);

  // ------------------------------------------------------------------ FIFO
  assign push = iST_DV && oST_READY;

  vport_fifo #(
    .W     (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (iCLK),
    .rst_n (iRESETn),
    .push  (push),
    .wdata ({iST_START, iST_DATA}),
    .pop   (pop),
    .head  (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_start = head[15];
  assign head_pix   = head[14:0];
  assign head_rgb   = {expand5(head_pix[R_LSB +: C5_W]),
                       expand5(head_pix[G_LSB +: C5_W]),
                       expand5(head_pix[B_LSB +: C5_W])};

  // pop is only raised with the FIFO non-empty and push only with room,
  // so this matches the FIFO's own count update.
  assign count_next = fifo_count + CW'(push) - CW'(pop);

  // ------------------------------------------------------- FSM decisions
  always_comb begin
    pop        = 1'b0;
    pix_rgb    = 24'h0;
    err        = 1'b0;
    state_next = state;
    case (state)
      SYNC: begin
        if (!fifo_empty) begin
          if (!head_start) begin
            pop = 1'b1;                       // garbage ahead of a frame start
          end else if (at_origin) begin
            pop        = 1'b1;
            pix_rgb    = head_rgb;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (de_raw) begin
          if (fifo_empty) begin
            pix_rgb    = UNDERRUN_RGB;
            err        = 1'b1;
            state_next = SYNC;
          end else if (head_start != at_origin) begin
            // Early start is kept for the next frame; a missing start is
            // left for SYNC to discard.
            err        = 1'b1;
            state_next = SYNC;
          end else begin
            pop     = 1'b1;
            pix_rgb = head_rgb;
          end
        end
      end
      default: state_next = SYNC;
    endcase
  end

  // ---------------------------------------------- state and output regs
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state     <= SYNC;
      oRED      <= 8'h0;
      oGRN      <= 8'h0;
      oBLU      <= 8'h0;
      oDE       <= 1'b0;
      oHS       <= ~HS_POL;
      oVS       <= ~VS_POL;
      oST_READY <= 1'b0;
      oUNDERRUN <= 1'b0;
    end else begin
      state              <= state_next;
      {oRED, oGRN, oBLU} <= de_raw ? pix_rgb : 24'h0;
      oDE                <= de_raw;
      oHS                <= hs_raw ? HS_POL : ~HS_POL;
      oVS                <= vs_raw ? VS_POL : ~VS_POL;
      oST_READY          <= (count_next < CW'(FIFO_DEPTH));
      if (err) begin
        oUNDERRUN <= 1'b1;
      end else if (iCLR_UNDERRUN) begin
        oUNDERRUN <= 1'b0;
      end
    end
  end

  assign oDBG_STATE = state;

endmodule
